// File: rtl/xoodyak_hash_arbiter.sv
// xoodyak_hash_arbiter
// Lets N_REQ requesters take turns on one XOODYAK hash core. Requests are
// served round-robin. Each job runs grant, core start, message streaming,
// digest forwarding and a completion pulse.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   req/req_len/req_msg   per-requester request, length and FWFT message byte
//   msg_rd                byte-consumed strobe to the granted requester
//   grant                 one-hot core owner
//   hash_out/hash_vld     digest byte (combinational) and per-requester valid
//   done/err              one-cycle job-complete / watchdog-abort pulses
//   arb_busy              high outside IDLE
//   core_*                hash core start, message, length, digest, busy
//
// Build option: XOODYAK_ARB_TIMEOUT_EN enables the WAIT/HASH watchdog.
// Without it, err is tied to 0.
//
// state  | meaning
// IDLE   | waiting for a request while the core is idle
// START  | one-cycle core_start carrying the latched length
// STREAM | one message byte to the core per cycle, length cycles
// WAIT   | waiting for the first digest byte
// HASH   | forwarding the remaining digest bytes
// DONE   | completion pulse; round-robin pointer advances
// ABORT  | watchdog abort pulse (watchdog builds only)
module xoodyak_hash_arbiter #(
  parameter int N_REQ       = 4,
  parameter int LEN_W       = 12,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  input  logic [N_REQ*8-1:0]     req_msg,
  output logic [N_REQ-1:0]       msg_rd,
  output logic [N_REQ-1:0]       grant,
  output logic [7:0]             hash_out,
  output logic [N_REQ-1:0]       hash_vld,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       err,
  output logic                   arb_busy,
  output logic                   core_start,
  output logic [7:0]             core_msg,
  output logic [LEN_W-1:0]       core_msg_len,
  input  logic [7:0]             core_hash,
  input  logic [7:0]             core_hash_len,
  input  logic                   core_valid,
  input  logic                   core_busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_STREAM, S_WAIT, S_HASH, S_DONE, S_ABORT
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, rr_q, win_idx;
  logic               win_vld;
  logic [LEN_W-1:0]   len_q, bcnt_q;
  logic [7:0]         hlen_q, hcnt_q;
  logic [N_REQ-1:0]   owner;

`ifdef XOODYAK_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q;
  logic            wd_hit;
  assign wd_hit = (state_q == S_WAIT || state_q == S_HASH) &&
                  (wd_q == WD_W'(TIMEOUT_CYC - 1));
`else
  localparam int timeout_unused = TIMEOUT_CYC;
`endif

  // Round-robin pick. Scanning from the farthest offset down leaves the
  // request closest above the pointer as the last, and so winning, write.
  always_comb begin
    int j;
    j       = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (win_vld && !core_busy) state_d = S_START;
      S_START:  state_d = (len_q != '0) ? S_STREAM : S_WAIT;
      S_STREAM: if (bcnt_q == len_q - 1'b1) state_d = S_WAIT;
      S_WAIT:   if (core_valid) state_d = S_HASH;
      // The first byte is counted in WAIT, so a stored length of 0 or 1 ends here.
      S_HASH:   if (hcnt_q >= hlen_q || !core_valid) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      S_ABORT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
`ifdef XOODYAK_ARB_TIMEOUT_EN
    if (wd_hit) state_d = S_ABORT;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      rr_q   <= '0;
      len_q  <= '0;
      bcnt_q <= '0;
      hlen_q <= '0;
      hcnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (state_d == S_START) begin
          idx_q <= win_idx;
          len_q <= req_len[int'(win_idx)*LEN_W +: LEN_W];
        end
        S_START:  bcnt_q <= '0;
        S_STREAM: bcnt_q <= bcnt_q + 1'b1;
        S_WAIT: if (core_valid) begin
          hlen_q <= core_hash_len;
          hcnt_q <= 8'd1;
        end
        S_HASH: if (core_valid && hcnt_q < hlen_q) hcnt_q <= hcnt_q + 1'b1;
        S_DONE, S_ABORT:
          rr_q <= (int'(idx_q) == N_REQ - 1) ? '0 : idx_q + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef XOODYAK_ARB_TIMEOUT_EN
  // The watchdog restarts on every state change, so WAIT and HASH each get a full budget.
  always_ff @(posedge clk) begin
    if (reset || state_d != state_q)                    wd_q <= '0;
    else if (state_q == S_WAIT || state_q == S_HASH)    wd_q <= wd_q + 1'b1;
  end
`endif

  assign owner        = N_REQ'(1) << idx_q;
  assign hash_out     = core_hash;
  assign core_msg_len = len_q;

  always_comb begin
    grant      = '0;
    msg_rd     = '0;
    hash_vld   = '0;
    done       = '0;
    err        = '0;
    core_start = 1'b0;
    core_msg   = '0;
    arb_busy   = (state_q != S_IDLE);
    if (state_q != S_IDLE) grant = owner;
    case (state_q)
      S_START:  core_start = 1'b1;
      S_STREAM: begin
        msg_rd   = owner;
        core_msg = req_msg[int'(idx_q)*8 +: 8];
      end
      S_WAIT:   if (core_valid) hash_vld = owner;
      S_HASH:   if (core_valid && hcnt_q < hlen_q) hash_vld = owner;
      S_DONE:   done = owner;
`ifdef XOODYAK_ARB_TIMEOUT_EN
      S_ABORT:  err = owner;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_xoodyak_hash_arbiter.sv
module tb_xoodyak_hash_arbiter;

  localparam int N = 4;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*LW-1:0] req_len;
  logic [N*8-1:0]  req_msg;
  logic [N-1:0]  msg_rd, grant, hash_vld, done, err;
  logic [7:0]    hash_out, core_msg, core_hash, core_hash_len;
  logic          arb_busy, core_start, core_valid, core_busy;
  logic [LW-1:0] core_msg_len;

  xoodyak_hash_arbiter #(.N_REQ(N), .LEN_W(LW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_len(req_len), .req_msg(req_msg),
    .msg_rd(msg_rd), .grant(grant), .hash_out(hash_out), .hash_vld(hash_vld),
    .done(done), .err(err), .arb_busy(arb_busy), .core_start(core_start),
    .core_msg(core_msg), .core_msg_len(core_msg_len), .core_hash(core_hash),
    .core_hash_len(core_hash_len), .core_valid(core_valid), .core_busy(core_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r; int len; int hlen; int nval; int exp_rd; int exp_vld;
  } row_t;

  int checks = 0;
  int errors = 0;

  // core model / monitor state
  int cyc = 0;
  int v_from = 0, v_to = 0;
  int m_nvalid = 0;
  logic [7:0] m_hlen = 8'd0;
  int ptr[N];
  int n_rd[N], n_vld[N], n_done[N], n_err[N];
  int rd_first[N], rd_last[N];
  bit prev_rd[N];
  int n_start = 0, start_len = 0, start_cyc = 0, err_cyc = 0, viol = 0;
  int order[$];

  task automatic tick; @(posedge clk); #1; endtask
  task automatic samp; @(negedge clk); #1; endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor at negedge, then drive core and requester data just after posedge.
  initial begin
    for (int i = 0; i < N; i++) begin
      ptr[i] = 0; n_rd[i] = 0; n_vld[i] = 0; n_done[i] = 0; n_err[i] = 0;
      rd_first[i] = 0; rd_last[i] = 0; prev_rd[i] = 0;
    end
    core_valid = 1'b0; core_hash = 8'd0; core_hash_len = 8'd0; req_msg = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        v_from = 0; v_to = 0;
        for (int i = 0; i < N; i++) begin ptr[i] = 0; prev_rd[i] = 0; end
      end else begin
        if (core_start) begin
          v_from = cyc + int'(core_msg_len) + 3;
          v_to = v_from + m_nvalid;
          start_len = int'(core_msg_len);
          start_cyc = cyc;
          n_start++;
          for (int i = 0; i < N; i++) if (grant[i]) order.push_back(i);
        end
        if ($countones(grant) > 1) viol++;
        if (arb_busy != (|grant)) viol++;
        if (|((msg_rd | hash_vld | done | err) & ~grant)) viol++;
        if (|hash_vld && (!core_valid || hash_out !== core_hash)) viol++;
        for (int i = 0; i < N; i++) begin
          if (msg_rd[i]) begin
            if (core_msg !== 8'(8'hA0 + 16*i + ptr[i])) viol++;
            if (!prev_rd[i]) rd_first[i] = cyc;
            rd_last[i] = cyc;
            ptr[i]++;
            n_rd[i]++;
          end
          prev_rd[i] = msg_rd[i];
          if (hash_vld[i]) n_vld[i]++;
          if (done[i]) n_done[i]++;
          if (err[i]) begin n_err[i]++; err_cyc = cyc; end
        end
      end
      @(posedge clk);
      cyc++;
      #1;
      core_valid = (cyc >= v_from) && (cyc < v_to);
      core_hash = 8'(8'h50 + cyc - v_from);
      core_hash_len = m_hlen;
      for (int i = 0; i < N; i++) req_msg[i*8 +: 8] = 8'(8'hA0 + 16*i + ptr[i]);
    end
  end

  task automatic wait_end(output int who, output int was_err);
    bit got;
    int k;
    who = -1; was_err = 0; got = 0; k = 0;
    while (!got && k < 400) begin
      samp;
      for (int i = 0; i < N; i++)
        if (done[i] || err[i]) begin who = i; was_err = int'(err[i]); got = 1; end
      tick;
      k++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL job_end_timeout: no done/err within 400 cycles");
    end else req[who] = 1'b0;
  endtask

  task automatic run_row(input row_t rw, input string tag);
    int b_rd, b_vld, b_done, b_start, who, we;
    b_rd = n_rd[rw.r]; b_vld = n_vld[rw.r]; b_done = n_done[rw.r]; b_start = n_start;
    m_nvalid = rw.nval;
    m_hlen = 8'(rw.hlen);
    req_len[rw.r*LW +: LW] = LW'(rw.len);
    req[rw.r] = 1'b1;
    wait_end(who, we);
    tick;
    samp;
    chk({tag, "_who"}, who, rw.r);
    chk({tag, "_err"}, we, 0);
    chk({tag, "_starts"}, n_start - b_start, 1);
    chk({tag, "_msg_len"}, start_len, rw.len);
    chk({tag, "_msg_rd"}, n_rd[rw.r] - b_rd, rw.exp_rd);
    chk({tag, "_hash_vld"}, n_vld[rw.r] - b_vld, rw.exp_vld);
    chk({tag, "_done"}, n_done[rw.r] - b_done, 1);
    chk({tag, "_grant_after"}, grant, 0);
    if (rw.exp_rd > 0) chk({tag, "_rd_span"}, rd_last[rw.r] - rd_first[rw.r] + 1, rw.exp_rd);
    tick;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    row_t rows[5];
    int who, we, b, bd, seen;
    rows[0] = '{r:0, len:3, hlen:4, nval:4, exp_rd:3, exp_vld:4};
    rows[1] = '{r:2, len:0, hlen:4, nval:4, exp_rd:0, exp_vld:4};
    rows[2] = '{r:1, len:5, hlen:3, nval:6, exp_rd:5, exp_vld:3};
    rows[3] = '{r:3, len:2, hlen:5, nval:2, exp_rd:2, exp_vld:2};
    rows[4] = '{r:0, len:1, hlen:0, nval:3, exp_rd:1, exp_vld:1};

    reset = 1'b1; req = '0; req_len = '0; core_busy = 1'b0;
    repeat (3) tick;
    samp;
    chk("reset_outputs", {grant, msg_rd, done, err, core_start, arb_busy, core_msg_len, core_msg}, 64'd0);
    tick;
    reset = 1'b0;
    tick;

    // arbitration order from pointer 0
    m_nvalid = 2; m_hlen = 8'd2;
    b = order.size();
    for (int i = 0; i < N; i++) req_len[i*LW +: LW] = 12'd1;
    req = 4'b0110;
    wait_end(who, we);
    wait_end(who, we);
    req = req | 4'b1010;
    wait_end(who, we);
    wait_end(who, we);
    tick;
    chk("arb_count", order.size() - b, 4);
    if (order.size() - b == 4) begin
      chk("arb_order0", order[b], 1);
      chk("arb_order1", order[b+1], 2);
      chk("arb_order2", order[b+2], 3);
      chk("arb_order3", order[b+3], 1);
    end

    for (int t = 0; t < 5; t++) run_row(rows[t], $sformatf("row%0d", t));

    // core_busy holds off the grant
    m_nvalid = 2; m_hlen = 8'd2;
    core_busy = 1'b1;
    req_len[0 +: LW] = 12'd2;
    req[0] = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      samp;
      if (grant != 0) seen = 1;
      tick;
    end
    chk("busy_hold", seen, 0);
    core_busy = 1'b0;
    samp;
    chk("busy_fall_cycle", grant, 4'b0000);
    tick;
    samp;
    chk("busy_grant_next", grant, 4'b0001);
    wait_end(who, we);
    chk("busy_job_who", who, 0);
    tick;

    // reset in the middle of streaming
    b = n_rd[2];
    req_len[2*LW +: LW] = 12'd8;
    req[2] = 1'b1;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      samp;
      if (n_rd[2] - b >= 2) seen = 1;
      tick;
    end
    chk("reset_reach_byte2", seen, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    req[2] = 1'b0;
    samp;
    chk("midjob_reset_outputs",
        {grant, msg_rd, done, err, hash_vld, core_start, arb_busy, core_msg_len, core_msg}, 64'd0);
    tick;
    run_row('{r:1, len:2, hlen:2, nval:2, exp_rd:2, exp_vld:2}, "post_reset");

`ifdef XOODYAK_ARB_TIMEOUT_EN
    // pointer now 2: requester 3 wins, times out, then requester 0 is granted
    m_nvalid = 0; m_hlen = 8'd4;
    bd = n_done[3];
    b = order.size();
    req_len[3*LW +: LW] = 12'd0;
    req_len[0 +: LW] = 12'd0;
    req = 4'b1001;
    wait_end(who, we);
    chk("wd_who", who, 3);
    chk("wd_is_err", we, 1);
    chk("wd_latency", err_cyc - start_cyc, 17);
    chk("wd_no_done", n_done[3] - bd, 0);
    wait_end(who, we);
    chk("wd_next_grant", (order.size() - b == 2) ? order[b+1] : -1, 0);
    tick;
`else
    chk("err_never", n_err[0] + n_err[1] + n_err[2] + n_err[3], 0);
`endif

    chk("monitor_violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
